// File: rtl/uart_io_port.sv
// rtl/uart_io_port.sv - CPU-side UART I/O port: byte TX with busy flag, RX with held interrupt and overrun.
module uart_io_port #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       w_req,
    input  logic [7:0] w_data,
    output logic       w_busy,
    input  logic       ack,
    output logic [7:0] r_data,
    output logic       intr_req,
    output logic       overrun,
    output logic       uart_tx,
    input  logic       uart_rx
);
    localparam int CW = $clog2(CLK_PER_BIT) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_tx;
    logic          r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_tx_shift <= w_data;
                        r_tx_state <= S_START;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_tx_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bit   <= '0;
                        r_tx_state <= S_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= S_STOP;
                        end else begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit   <= r_tx_bit + 1'b1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: begin
                    // busy drops with the return to IDLE so the next w_req lands the same cycle
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_busy     <= 1'b0;
                        r_tx_state <= S_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign uart_tx = r_tx;
    assign w_busy  = r_busy;

    logic [1:0]    r_sync;
    logic          r_rx_prev;
    logic [1:0]    r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_data_q;
    logic          r_intr;
    logic          r_ovr;
    logic          w_rx_s;
    logic          w_rx_done;

    assign w_rx_s    = r_sync[1];
    assign w_rx_done = (r_rx_state == S_STOP) && (r_rx_cnt == BIT_LAST) && w_rx_s;

    // Falling-edge arming via r_rx_prev also makes a framing error wait for the line to go idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync     <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_sync    <= {r_sync[0], uart_rx};
            r_rx_prev <= w_rx_s;
            case (r_rx_state)
                S_IDLE: begin
                    if (r_rx_prev && !w_rx_s) begin
                        r_rx_state <= S_START;
                        r_rx_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx_s, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= S_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= S_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // A completion outranks a simultaneous ack; the ack still clears the prior overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_q <= '0;
            r_intr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else if (w_rx_done) begin
            r_data_q <= r_rx_shift;
            r_intr   <= 1'b1;
            r_ovr    <= r_intr && !ack;
        end else if (ack) begin
            r_intr <= 1'b0;
            r_ovr  <= 1'b0;
        end
    end

    assign r_data   = r_data_q;
    assign intr_req = r_intr;
    assign overrun  = r_ovr;
endmodule
